// File: rtl/data_mem_responder.sv
// Data-memory responder: request/response handshake in front of a 64-bit
// doubleword array, with programmable wait states and error reporting.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_error,
   output logic [15:0] access_count
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 3;
   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               write_q, write_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [63:0]        wdata_q, wdata_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [63:0]        rsp_rdata_q, rsp_rdata_d;
   logic               rsp_error_q, rsp_error_d;
   logic [15:0]        access_count_q, access_count_d;
   logic               mem_we_c;

   logic [63:0] mem [DEPTH];

   assign req_ready    = (state_q == S_IDLE) && resetl;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_error    = rsp_error_q;
   assign access_count = access_count_q;

   // Next-state logic; the counter runs WAIT_STATES cycles, then the commit cycle.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      write_d        = write_q;
      err_d          = err_q;
      idx_d          = idx_q;
      wdata_d        = wdata_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_error_d    = rsp_error_q;
      access_count_d = access_count_q;
      mem_we_c       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(WAIT_STATES);
               write_d = req_write;
               idx_d   = req_addr[ADDR_WIDTH-1:3];
               wdata_d = req_wdata;
               err_d   = (req_addr[2:0] != 3'b000) || (req_addr[63:ADDR_WIDTH] != '0);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               rsp_error_d = err_q;
               rsp_rdata_d = (err_q || write_q) ? 64'd0 : mem[idx_q];
               mem_we_c    = write_q && !err_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d        = S_IDLE;
               rsp_valid_d    = 1'b0;
               rsp_error_d    = 1'b0;
               access_count_d = access_count_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         write_q        <= 1'b0;
         err_q          <= 1'b0;
         idx_q          <= '0;
         wdata_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_error_q    <= 1'b0;
         access_count_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         write_q        <= write_d;
         err_q          <= err_d;
         idx_q          <= idx_d;
         wdata_q        <= wdata_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_error_q    <= rsp_error_d;
         access_count_q <= access_count_d;
      end
   end

   // Array contents survive reset; a reset in WAIT returns to IDLE before any write.
   always_ff @(posedge CLK) begin
      if (mem_we_c) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table plus scoreboard, with a WAIT_STATES=2
// instance (dut) and a WAIT_STATES=0 instance (dut0) selected by sel.
module tb_data_mem_responder;

   localparam int unsigned WS_A = 2;

   typedef struct {
      logic        w;
      logic [63:0] a;
      logic [63:0] d;
      logic [63:0] exp_d;
      logic        exp_e;
      int          bp;
   } vec_t;

   typedef struct {
      logic [63:0] d;
      logic        e;
   } exp_t;

   logic        CLK, resetl, sel;
   logic        req_valid, req_write, rsp_ready;
   logic [63:0] req_addr, req_wdata;
   logic        rr2, rv2, re2, rr0, rv0, re0;
   logic [63:0] rd2, rd0;
   logic [15:0] ac2, ac0;
   logic        rdy, rv, re;
   logic [63:0] rd;
   logic [15:0] ac;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_cnt [2];
   exp_t        sb [$];
   vec_t        vecs [13];

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS_A)) dut (
      .CLK(CLK), .resetl(resetl),
      .req_valid(req_valid & ~sel), .req_ready(rr2), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv2), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd2),
      .rsp_error(re2), .access_count(ac2));

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
      .CLK(CLK), .resetl(resetl),
      .req_valid(req_valid & sel), .req_ready(rr0), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd0),
      .rsp_error(re0), .access_count(ac0));

   assign rdy = sel ? rr0 : rr2;
   assign rv  = sel ? rv0 : rv2;
   assign re  = sel ? re0 : re2;
   assign rd  = sel ? rd0 : rd2;
   assign ac  = sel ? ac0 : ac2;

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", nm, act, exp, $time, sel);
      end
   endtask

   // Present one request from a negedge and drop it after the accepting posedge.
   task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d);
      int n = 0;
      while (rdy !== 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_wait", 64'(rdy), 64'd1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge CLK);
      req_valid = 1'b0;
   endtask

   task automatic run_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] ed, input logic ee, input int bp);
      exp_t e;
      int   lat = 0;
      int   lat_exp;
      sb.push_back('{ed, ee});
      issue(w, a, d);
      lat_exp = sel ? 1 : int'(WS_A) + 1;
      while (rv !== 1'b1 && lat < 60) begin
         @(negedge CLK);
         lat++;
      end
      chk("latency", 64'(lat), 64'(lat_exp));
      e = sb.pop_front();
      chk("rdata", rd, e.d);
      chk("error", 64'(re), 64'(e.e));
      chk("req_ready_busy", 64'(rdy), 64'd0);
      for (int i = 0; i < bp; i++) begin
         @(negedge CLK);
         chk("bp_valid", 64'(rv), 64'd1);
         chk("bp_rdata", rd, e.d);
         chk("bp_error", 64'(re), 64'(e.e));
         chk("bp_req_ready", 64'(rdy), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      exp_cnt[sel] = exp_cnt[sel] + 16'd1;
      chk("consumed_valid", 64'(rv), 64'd0);
      chk("consumed_error", 64'(re), 64'd0);
      chk("rdata_held", rd, e.d);
      chk("access_count", 64'(ac), 64'(exp_cnt[sel]));
      chk("ready_after", 64'(rdy), 64'd1);
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, "_valid"}, 64'(rv), 64'd0);
      chk({nm, "_ready"}, 64'(rdy), 64'd0);
      chk({nm, "_count"}, 64'(ac), 64'd0);
      chk({nm, "_error"}, 64'(re), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 0};
      vecs[1]  = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0};
      vecs[2]  = '{1'b0, 64'h13,  64'h0, 64'h0, 1'b1, 0};
      vecs[3]  = '{1'b0, 64'h400, 64'h0, 64'h0, 1'b1, 0};
      vecs[4]  = '{1'b0, 64'h10,  64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 5};
      vecs[5]  = '{1'b1, 64'h3F8, 64'h01234567_89ABCDEF, 64'h0, 1'b0, 0};
      vecs[6]  = '{1'b0, 64'h3F8, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 2};
      vecs[7]  = '{1'b0, 64'h80000000_00000000, 64'h0, 64'h0, 1'b1, 0};
      vecs[8]  = '{1'b1, 64'h18,  64'h1111, 64'h0, 1'b0, 0};
      vecs[9]  = '{1'b1, 64'h1C,  64'h2222, 64'h0, 1'b1, 0};
      vecs[10] = '{1'b0, 64'h18,  64'h0, 64'h1111, 1'b0, 0};
      vecs[11] = '{1'b1, 64'h418, 64'h3333, 64'h0, 1'b1, 1};
      vecs[12] = '{1'b0, 64'h18,  64'h0, 64'h1111, 1'b0, 0};

      CLK = 1'b0; resetl = 1'b1; sel = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
      req_addr = '0; req_wdata = '0;
      exp_cnt[0] = '0; exp_cnt[1] = '0;
      #2 resetl = 1'b0;
      #1 check_reset_state("reset");
      chk("reset_rdata", rd, 64'd0);
      repeat (2) @(negedge CLK);
      resetl = 1'b1;
      @(negedge CLK);

      // Table-driven pass on the WAIT_STATES=2 instance
      for (int i = 0; i < 13; i++)
         run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d, vecs[i].exp_e, vecs[i].bp);

      // Zero wait states: store then load, rsp_ready high while idle has no effect
      sel = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk("idle_ready_noeffect", 64'(ac), 64'd0);
      run_txn(1'b1, 64'h8, 64'h1234, 64'h0, 1'b0, 0);
      run_txn(1'b0, 64'h8, 64'h0, 64'h1234, 1'b0, 0);
      sel = 1'b0;
      @(negedge CLK);

      // Reset during WAIT aborts a store
      run_txn(1'b1, 64'h20, 64'hAA, 64'h0, 1'b0, 0);
      issue(1'b1, 64'h20, 64'h55);
      resetl = 1'b0;
      #1 check_reset_state("rst_wait");
      @(negedge CLK);
      check_reset_state("rst_wait_hold");
      resetl = 1'b1;
      exp_cnt[0] = '0; exp_cnt[1] = '0;
      @(negedge CLK);
      run_txn(1'b0, 64'h20, 64'h0, 64'hAA, 1'b0, 0);

      // Reset during RESP drops the response but keeps the committed store
      issue(1'b1, 64'h28, 64'h77);
      for (int n = 0; n < 60 && rv !== 1'b1; n++) @(negedge CLK);
      chk("resp_before_reset", 64'(rv), 64'd1);
      resetl = 1'b0;
      #1 check_reset_state("rst_resp");
      @(negedge CLK);
      resetl = 1'b1;
      exp_cnt[0] = '0;
      @(negedge CLK);
      run_txn(1'b0, 64'h28, 64'h0, 64'h77, 1'b0, 0);

      // Counter wrap: preload near the top instead of 65k real transactions
      force dut.access_count_q = 16'hFFFE;
      @(negedge CLK);
      release dut.access_count_q;
      exp_cnt[0] = 16'hFFFE;
      run_txn(1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0);
      run_txn(1'b0, 64'h3F8, 64'h0, 64'h01234567_89ABCDEF, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
